// File: rtl/rv32i_pkg.sv
// Shared RV32I definitions: load/store funct3 codes, LSU FSM states
// and ALU control codes.
package rv32i_pkg;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    typedef enum logic [1:0] {
        LSU_IDLE = 2'd0,
        LSU_BUSY = 2'd1,
        LSU_RESP = 2'd2
    } lsu_state_e;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_SLL  = 4'd2,
        ALU_SLT  = 4'd3,
        ALU_SLTU = 4'd4,
        ALU_XOR  = 4'd5,
        ALU_SRL  = 4'd6,
        ALU_SRA  = 4'd7,
        ALU_OR   = 4'd8,
        ALU_AND  = 4'd9
    } alu_op_e;

    // Loads accept 000/001/010/100/101; stores accept 000/001/010.
    function automatic logic f3_legal(input logic we, input logic [2:0] f3);
        if (we)
            return (f3[2] == 1'b0) && (f3[1:0] != 2'b11);
        return (f3[1:0] != 2'b11) && (f3 != 3'b110);
    endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Data-memory bus between the load/store unit (master) and memory (slave).
interface load_store_unit_if;

    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_ready;
    logic [31:0] mem_rdata;

    modport master (
        output mem_req,
        output mem_we,
        output mem_addr,
        output mem_wdata,
        output mem_be,
        input  mem_ready,
        input  mem_rdata
    );

    modport slave (
        input  mem_req,
        input  mem_we,
        input  mem_addr,
        input  mem_wdata,
        input  mem_be,
        output mem_ready,
        output mem_rdata
    );

endinterface

// File: rtl/lsu_align.sv
// Lane selection, load extension, store replication and byte enables.
// LSU_MISALIGN_TRAP_EN flags unaligned halfword/word accesses instead of masking.
module lsu_align
    import rv32i_pkg::*;
(
    input  logic        req_we,
    input  logic [2:0]  funct3,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] wdata,
    output logic        legal,
    output logic        misaligned,
    output logic [1:0]  lane,
    output logic [3:0]  be,
    output logic [31:0] wdata_rep,
    input  logic [2:0]  load_funct3,
    input  logic [1:0]  load_lane,
    input  logic [31:0] mem_rdata,
    output logic [31:0] load_data
);

    logic [31:0] shifted;

    always_comb begin
        legal     = f3_legal(req_we, funct3);
        lane      = addr_lo;
        be        = 4'b0000;
        wdata_rep = 32'h0;
        // Halfwords snap to an even lane, words to lane 0.
        case (funct3[1:0])
            2'b01:   lane = {addr_lo[1], 1'b0};
            2'b10:   lane = 2'b00;
            default: lane = addr_lo;
        endcase
        if (req_we) begin
            case (funct3)
                F3_SB: begin
                    be        = 4'b0001 << lane;
                    wdata_rep = {4{wdata[7:0]}};
                end
                F3_SH: begin
                    be        = 4'b0011 << lane;
                    wdata_rep = {2{wdata[15:0]}};
                end
                F3_SW: begin
                    be        = 4'b1111;
                    wdata_rep = wdata;
                end
                default: begin
                    be        = 4'b0000;
                    wdata_rep = 32'h0;
                end
            endcase
        end
    end

`ifdef LSU_MISALIGN_TRAP_EN
    always_comb begin
        misaligned = ((funct3[1:0] == 2'b01) && addr_lo[0])
                  || ((funct3[1:0] == 2'b10) && (addr_lo != 2'b00));
    end
`else
    assign misaligned = 1'b0;
`endif

    always_comb begin
        shifted   = mem_rdata >> {load_lane, 3'b000};
        load_data = 32'h0;
        case (load_funct3)
            F3_LB:   load_data = {{24{shifted[7]}}, shifted[7:0]};
            F3_LH:   load_data = {{16{shifted[15]}}, shifted[15:0]};
            F3_LW:   load_data = mem_rdata;
            F3_LBU:  load_data = {24'h0, shifted[7:0]};
            F3_LHU:  load_data = {16'h0, shifted[15:0]};
            default: load_data = 32'h0;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// RV32I load/store unit: IDLE/BUSY/RESP FSM with bus timeout.
// Define LSU_MISALIGN_TRAP_EN to trap misaligned accesses via misalign.
module load_store_unit
    import rv32i_pkg::*;
#(
    parameter int MAX_WAIT = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    input  logic        req_we,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        stall,
    output logic        done,
    output logic [31:0] rdata,
    output logic        err,
    output logic        misalign,
    load_store_unit_if.master mem
);

    localparam logic [7:0] WAIT_LAST = 8'(MAX_WAIT - 1);

    lsu_state_e  state;
    lsu_state_e  state_nxt;
    logic [7:0]  cnt;
    logic [2:0]  f3_q;
    logic [1:0]  lane_q;
    logic        legal;
    logic        mis_raw;
    logic [1:0]  lane;
    logic [3:0]  be;
    logic [31:0] wdata_rep;
    logic [31:0] load_data;
    logic        in_idle;
    logic        accept;
    logic        bad;
    logic        timeout;

    lsu_align u_align (
        .req_we      (req_we),
        .funct3      (funct3),
        .addr_lo     (addr[1:0]),
        .wdata       (wdata),
        .legal       (legal),
        .misaligned  (mis_raw),
        .lane        (lane),
        .be          (be),
        .wdata_rep   (wdata_rep),
        .load_funct3 (f3_q),
        .load_lane   (lane_q),
        .mem_rdata   (mem.mem_rdata),
        .load_data   (load_data)
    );

    assign in_idle = (state == LSU_IDLE);
    assign accept  = in_idle && req_valid && legal && !mis_raw;
    assign bad     = in_idle && req_valid && !legal;
    assign timeout = (state == LSU_BUSY) && !mem.mem_ready
                  && (cnt == WAIT_LAST);

    always_ff @(posedge clk) begin
        if (reset)
            state <= LSU_IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt   = state;
        stall       = 1'b0;
        done        = 1'b0;
        misalign    = 1'b0;
        mem.mem_req = 1'b0;
        case (state)
            LSU_IDLE: begin
                misalign = req_valid && legal && mis_raw;
                stall    = accept;
                if (accept)
                    state_nxt = LSU_BUSY;
                else if (bad)
                    state_nxt = LSU_RESP;
            end
            LSU_BUSY: begin
                stall       = 1'b1;
                mem.mem_req = 1'b1;
                if (mem.mem_ready || timeout)
                    state_nxt = LSU_RESP;
            end
            LSU_RESP: begin
                done      = 1'b1;
                state_nxt = LSU_IDLE;
            end
            default: state_nxt = LSU_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt           <= 8'd0;
            f3_q          <= 3'b000;
            lane_q        <= 2'b00;
            rdata         <= 32'h0;
            err           <= 1'b0;
            mem.mem_we    <= 1'b0;
            mem.mem_addr  <= 32'h0;
            mem.mem_wdata <= 32'h0;
            mem.mem_be    <= 4'b0000;
        end else begin
            case (state)
                LSU_IDLE: begin
                    if (accept) begin
                        cnt           <= 8'd0;
                        f3_q          <= funct3;
                        lane_q        <= lane;
                        mem.mem_we    <= req_we;
                        mem.mem_addr  <= {addr[31:2], 2'b00};
                        mem.mem_wdata <= wdata_rep;
                        mem.mem_be    <= be;
                    end else if (bad) begin
                        err   <= 1'b1;
                        rdata <= 32'h0;
                    end
                end
                LSU_BUSY: begin
                    if (mem.mem_ready) begin
                        err   <= 1'b0;
                        rdata <= mem.mem_we ? 32'h0 : load_data;
                    end else if (timeout) begin
                        err   <= 1'b1;
                        rdata <= 32'h0;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed, table-driven bench for load_store_unit with a simple
// memory responder that answers after a programmable number of BUSY cycles.
module tb_load_store_unit;
    import rv32i_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_we;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        stall;
    logic        done;
    logic [31:0] rdata;
    logic        err;
    logic        misalign;

    load_store_unit_if mem_bus();

    load_store_unit #(.MAX_WAIT(16)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_we    (req_we),
        .funct3    (funct3),
        .addr      (addr),
        .wdata     (wdata),
        .stall     (stall),
        .done      (done),
        .rdata     (rdata),
        .err       (err),
        .misalign  (misalign),
        .mem       (mem_bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] mrd;
        int          delay;
        logic [31:0] exp_rdata;
        logic        exp_err;
        int          exp_stall;
        int          exp_req;
        logic [31:0] exp_maddr;
        logic [3:0]  exp_be;
        logic [31:0] exp_wdata;
    } vec_t;

    int checks = 0;
    int errors = 0;

    int          ready_delay = 0;
    logic [31:0] mem_rdata_val = 32'h0;
    logic        stray_ready = 1'b0;
    int          busy_cnt = 0;
    int          req_cycles = 0;
    int          unstable = 0;
    logic [31:0] cap_addr = 32'h0;
    logic [31:0] cap_wdata = 32'h0;
    logic [3:0]  cap_be = 4'h0;
    logic        cap_we = 1'b0;

    // Memory model: answers after ready_delay BUSY cycles, logs the bus.
    initial begin
        mem_bus.mem_ready = 1'b0;
        mem_bus.mem_rdata = 32'h0;
        forever begin
            @(posedge clk);
            #1;
            if (mem_bus.mem_req) begin
                if (busy_cnt == 0) begin
                    cap_addr  = mem_bus.mem_addr;
                    cap_wdata = mem_bus.mem_wdata;
                    cap_be    = mem_bus.mem_be;
                    cap_we    = mem_bus.mem_we;
                end else if (mem_bus.mem_addr !== cap_addr
                          || mem_bus.mem_wdata !== cap_wdata
                          || mem_bus.mem_be !== cap_be
                          || mem_bus.mem_we !== cap_we) begin
                    unstable++;
                end
                mem_bus.mem_ready = (busy_cnt == ready_delay);
                busy_cnt++;
                req_cycles++;
            end else begin
                busy_cnt = 0;
                mem_bus.mem_ready = stray_ready;
            end
            mem_bus.mem_rdata = mem_rdata_val;
        end
    end

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(
        input logic we, input logic [2:0] f3, input logic [31:0] a,
        input logic [31:0] wd, input logic [31:0] mrd, input int dly,
        input logic [31:0] erd, input logic eerr, input int est,
        input int ereq, input logic [31:0] ema, input logic [3:0] ebe,
        input logic [31:0] ewd);
        vec_t v;
        v.we = we; v.f3 = f3; v.addr = a; v.wdata = wd; v.mrd = mrd;
        v.delay = dly; v.exp_rdata = erd; v.exp_err = eerr;
        v.exp_stall = est; v.exp_req = ereq; v.exp_maddr = ema;
        v.exp_be = ebe; v.exp_wdata = ewd;
        return v;
    endfunction

    task automatic run_txn(input vec_t v, input string tag);
        int  stall_cnt;
        bit  got;
        req_cycles    = 0;
        unstable      = 0;
        ready_delay   = v.delay;
        mem_rdata_val = v.mrd;
        @(posedge clk);
        #1;
        req_valid = 1'b1;
        req_we    = v.we;
        funct3    = v.f3;
        addr      = v.addr;
        wdata     = v.wdata;
        @(negedge clk);
        check($sformatf("%s/misalign", tag), misalign, 0);
        stall_cnt = 0;
        got = 1'b0;
        for (int n = 0; n < 60; n++) begin
            if (n > 0) @(negedge clk);
            if (stall) stall_cnt++;
            if (done) begin
                got = 1'b1;
                break;
            end
        end
        check($sformatf("%s/done", tag), got, 1);
        if (got) begin
            if (!v.we)
                check($sformatf("%s/rdata", tag), rdata, v.exp_rdata);
            check($sformatf("%s/err", tag), err, v.exp_err);
        end
        check($sformatf("%s/stall_cycles", tag), stall_cnt, v.exp_stall);
        check($sformatf("%s/req_cycles", tag), req_cycles, v.exp_req);
        if (v.exp_req > 0) begin
            check($sformatf("%s/mem_addr", tag), cap_addr, v.exp_maddr);
            check($sformatf("%s/mem_be", tag), cap_be, v.exp_be);
            check($sformatf("%s/mem_wdata", tag), cap_wdata, v.exp_wdata);
            check($sformatf("%s/mem_we", tag), cap_we, v.we);
            check($sformatf("%s/bus_stable", tag), unstable, 0);
        end
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(negedge clk);
        check($sformatf("%s/done_pulse", tag), done, 0);
        check($sformatf("%s/stall_after", tag), stall, 0);
    endtask

    vec_t vecs[$];

    initial begin
        int dcount;
        reset     = 1'b1;
        req_valid = 1'b0;
        req_we    = 1'b0;
        funct3    = 3'b000;
        addr      = 32'h0;
        wdata     = 32'h0;

        // we f3 addr wdata mrd delay | rdata err stall req maddr be wdata
        vecs.push_back(mk(0, F3_LW, 32'h100, 0, 32'hDEADBEEF, 2,
                          32'hDEADBEEF, 0, 4, 3, 32'h100, 4'b0000, 0));
        vecs.push_back(mk(0, F3_LB, 32'h103, 0, 32'h80FFFF00, 0,
                          32'hFFFFFF80, 0, 2, 1, 32'h100, 4'b0000, 0));
        vecs.push_back(mk(0, F3_LBU, 32'h103, 0, 32'h80FFFF00, 0,
                          32'h00000080, 0, 2, 1, 32'h100, 4'b0000, 0));
        vecs.push_back(mk(0, F3_LB, 32'h100, 0, 32'h1234567F, 1,
                          32'h0000007F, 0, 3, 2, 32'h100, 4'b0000, 0));
        vecs.push_back(mk(0, F3_LH, 32'h102, 0, 32'h80011234, 0,
                          32'hFFFF8001, 0, 2, 1, 32'h100, 4'b0000, 0));
        vecs.push_back(mk(0, F3_LHU, 32'h100, 0, 32'h8001F234, 0,
                          32'h0000F234, 0, 2, 1, 32'h100, 4'b0000, 0));
        vecs.push_back(mk(1, F3_SH, 32'h202, 32'h0000ABCD, 0, 1,
                          0, 0, 3, 2, 32'h200, 4'b1100, 32'hABCDABCD));
        vecs.push_back(mk(1, F3_SB, 32'h301, 32'h12345678, 0, 0,
                          0, 0, 2, 1, 32'h300, 4'b0010, 32'h78787878));
        vecs.push_back(mk(1, F3_SW, 32'h404, 32'hCAFEF00D, 0, 0,
                          0, 0, 2, 1, 32'h404, 4'b1111, 32'hCAFEF00D));
        vecs.push_back(mk(0, 3'b011, 32'h100, 0, 0, 0,
                          0, 1, 0, 0, 0, 4'b0000, 0));
        vecs.push_back(mk(1, 3'b100, 32'h100, 32'h1, 0, 0,
                          0, 1, 0, 0, 0, 4'b0000, 0));
        vecs.push_back(mk(0, F3_LW, 32'h500, 0, 32'h11111111, 255,
                          0, 1, 17, 16, 32'h500, 4'b0000, 0));
`ifndef LSU_MISALIGN_TRAP_EN
        vecs.push_back(mk(0, F3_LH, 32'h101, 0, 32'h56789ABC, 0,
                          32'hFFFF9ABC, 0, 2, 1, 32'h100, 4'b0000, 0));
        vecs.push_back(mk(0, F3_LW, 32'h106, 0, 32'h01020304, 0,
                          32'h01020304, 0, 2, 1, 32'h104, 4'b0000, 0));
`endif

        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check("rst/stall", stall, 0);
        check("rst/done", done, 0);
        check("rst/rdata", rdata, 0);
        check("rst/err", err, 0);
        check("rst/misalign", misalign, 0);
        check("rst/mem_req", mem_bus.mem_req, 0);
        check("rst/mem_we", mem_bus.mem_we, 0);
        check("rst/mem_addr", mem_bus.mem_addr, 0);
        check("rst/mem_wdata", mem_bus.mem_wdata, 0);
        check("rst/mem_be", mem_bus.mem_be, 0);

        foreach (vecs[i])
            run_txn(vecs[i], $sformatf("vec%0d", i));

        // Stray mem_ready outside BUSY must not complete anything.
        stray_ready = 1'b1;
        dcount = 0;
        repeat (4) begin
            @(negedge clk);
            if (done || stall) dcount++;
        end
        check("stray/idle", dcount, 0);
        run_txn(mk(0, F3_LW, 32'h700, 0, 32'hA5A5A5A5, 1,
                   32'hA5A5A5A5, 0, 3, 2, 32'h700, 4'b0000, 0), "stray");
        stray_ready = 1'b0;

        // Reset in the middle of a BUSY transfer.
        ready_delay = 255;
        @(posedge clk);
        #1;
        req_valid = 1'b1;
        req_we    = 1'b0;
        funct3    = F3_LW;
        addr      = 32'h600;
        repeat (3) @(posedge clk);
        #1;
        reset     = 1'b1;
        req_valid = 1'b0;
        @(negedge clk);
        check("rstbusy/pre_req", mem_bus.mem_req, 1);
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check("rstbusy/mem_req", mem_bus.mem_req, 0);
        check("rstbusy/stall", stall, 0);
        check("rstbusy/done", done, 0);
        dcount = 0;
        repeat (20) begin
            @(negedge clk);
            if (done || mem_bus.mem_req) dcount++;
        end
        check("rstbusy/quiet", dcount, 0);
        run_txn(vecs[0], "after_rst");

`ifdef LSU_MISALIGN_TRAP_EN
        req_cycles = 0;
        @(posedge clk);
        #1;
        req_valid = 1'b1;
        req_we    = 1'b0;
        funct3    = F3_LH;
        addr      = 32'h101;
        @(negedge clk);
        check("mis_lh/misalign", misalign, 1);
        check("mis_lh/stall", stall, 0);
        check("mis_lh/mem_req", mem_bus.mem_req, 0);
        @(posedge clk);
        #1;
        req_we = 1'b1;
        funct3 = F3_SW;
        addr   = 32'h102;
        @(negedge clk);
        check("mis_sw/misalign", misalign, 1);
        check("mis_sw/stall", stall, 0);
        dcount = 0;
        repeat (3) begin
            @(negedge clk);
            if (done) dcount++;
        end
        check("mis/no_done", dcount, 0);
        check("mis/req_cycles", req_cycles, 0);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(negedge clk);
        check("mis/clear", misalign, 0);
`endif

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 Parameter MAX_WAIT, default 16: maximum cycles in BUSY before a bus timeout; legal range 2..255.
REQ-002 clk  input  1  single rising-edge clock.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 req_valid  input  1  the current instruction is a load or store.
REQ-005 req_we  input  1  1 = store, 0 = load.
REQ-006 funct3  input  3  RV32I load/store width and sign field.
REQ-007 addr  input  32  effective address, taken from the ALU result (data1 + data2).
REQ-008 wdata  input  32  store data (rs2).
REQ-009 stall  output  1  freeze PC and register-file write while high.
REQ-010 done  output  1  one-cycle pulse when the access completes; rdata and err are valid in that cycle.
REQ-011 rdata  output  32  load result after alignment and extension.
REQ-012 err  output  1  timeout or illegal funct3; qualified by done.
REQ-013 misalign  output  1  misaligned-access flag (see Configuration).
REQ-014 mem_req / mem_we  output  1 each  data-memory request and write strobe.
REQ-015 mem_addr  output  32  word-aligned address ({addr[31:2], 2'b00}).
REQ-016 mem_wdata / mem_be  output  32 / 4  lane-replicated store data and byte enables.
REQ-017 mem_ready / mem_rdata  input  1 / 32  memory completion and read word.

Function
REQ-018 The FSM SHALL have three states: IDLE, BUSY and RESP.
  - IDLE: a legal req_valid registers addr[1:0], funct3, req_we, mem_be and mem_wdata, then moves to BUSY.
  - BUSY: mem_req = 1, and all mem_* outputs are held stable.
  - RESP: lasts one cycle, then returns to IDLE.
REQ-019 stall SHALL equal (IDLE & req_valid & legal & !misalign) | BUSY, and SHALL be low in RESP.
REQ-020 In BUSY, mem_ready = 1 SHALL capture the extended mem_rdata into rdata and move to RESP; minimum latency from req_valid to done is 2 cycles.
REQ-021 A wait counter SHALL clear on entry to BUSY; if MAX_WAIT cycles elapse without mem_ready, the FSM SHALL drop mem_req and enter RESP with err = 1 and rdata = 0.
REQ-022 done SHALL be 1 only in RESP; req_valid SHALL be ignored in RESP, because the same instruction is still presented.
REQ-023 Loads SHALL select the addressed lane and then extend the result:
  - LB / LH: sign-extend.
  - LBU / LHU: zero-extend.
  - LW: whole word.
REQ-024 Stores SHALL set byte enables and replicate data across lanes:
  - SB: mem_be = 0001 << addr[1:0], byte replicated to all four lanes.
  - SH: mem_be = 0011 << (2*addr[1]), halfword replicated to both halves.
  - SW: mem_be = 1111.
REQ-025 mem_be SHALL be 0000 for loads; mem_we = req_we.
REQ-026 Illegal funct3 (loads 011/110/111, stores 1xx) SHALL issue no mem_req, go IDLE→RESP directly, and set err = 1.
REQ-027 If mem_ready is asserted outside BUSY, it SHALL be ignored.

Reset
REQ-028 An edge with reset high SHALL force IDLE and clear the counter; this applies mid-transfer too, so mem_req is low in the following cycle.
REQ-029 Reset values SHALL be 0 for stall, done, rdata, err, misalign, mem_req, mem_we, mem_addr, mem_wdata and mem_be.

Configuration
REQ-030 With LSU_MISALIGN_TRAP_EN defined:
  - A halfword with addr[0] = 1, or a word with addr[1:0] ≠ 00, SHALL assert misalign combinationally in IDLE.
  - It SHALL issue no mem_req and no stall.
REQ-031 Without LSU_MISALIGN_TRAP_EN:
  - misalign SHALL be tied to 0.
  - addr[0] SHALL be ignored for halfwords, and addr[1:0] for words.

Structure
REQ-032 Funct3 encodings (LB/LH/LW/LBU/LHU/SB/SH/SW) and the FSM state encodings SHALL live in the shared package rv32i_pkg, alongside the ALU control codes.
REQ-033 Lane selection, extension and byte-enable logic SHALL live in one combinational sub-module, lsu_align; the FSM and counter stay in load_store_unit.

Verification
REQ-034 LW at 0x100, mem_ready after 3 cycles with mem_rdata 0xDEADBEEF -> stall high for 4 cycles, done pulse, rdata 0xDEADBEEF.
REQ-035 LB at 0x103 with mem_rdata 0x80FF_FF00 -> rdata 0xFFFFFF80; LBU at the same address -> 0x00000080.
REQ-036 SH at 0x202 with wdata 0x0000ABCD -> mem_addr 0x200, mem_be 1100, mem_wdata 0xABCDABCD, mem_we 1.
REQ-037 LW with mem_ready never asserted -> mem_req drops after 16 cycles, done with err = 1 and rdata = 0.
REQ-038 LH at 0x101 -> with LSU_MISALIGN_TRAP_EN: misalign = 1, no mem_req, stall = 0; without it: access proceeds at 0x100, lanes [15:0].
REQ-039 reset asserted in BUSY -> next cycle mem_req = 0, stall = 0 and state IDLE; funct3 = 011 load -> done with err = 1 and no mem_req.
